// File: rtl/alu_flag_sequencer_pkg.sv
// Shared types and constants for the ALU flag sequencer.
// Define ALU_FLAG_SEQ_CARRY_EN to add a carry flag as status bit 3.
package alu_flag_sequencer_pkg;

`ifdef ALU_FLAG_SEQ_CARRY_EN
    localparam int unsigned STATUS_W = 4;
    localparam int unsigned FLAG_C   = 3;
`else
    localparam int unsigned STATUS_W = 3;
`endif

    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_V = 2;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_NOT = 3'd5,
        OP_SHL = 3'd6,
        OP_SHR = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_FLAG = 2'd2,
        S_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/alu_flag_compute.sv
// Combinational ALU datapath: result plus zero/negative/overflow flags.
// Carry flag generated only when ALU_FLAG_SEQ_CARRY_EN is defined.
module alu_flag_compute
    import alu_flag_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  op_e                 op_i,
    input  logic [WIDTH-1:0]    a_i,
    input  logic [WIDTH-1:0]    b_i,
    output logic [WIDTH-1:0]    result_o,
    output logic [STATUS_W-1:0] flags_o
);

    logic ovf;
`ifdef ALU_FLAG_SEQ_CARRY_EN
    logic carry;
`endif

    always_comb begin
        result_o = '0;
        ovf      = 1'b0;
`ifdef ALU_FLAG_SEQ_CARRY_EN
        carry    = 1'b0;
`endif
        unique case (op_i)
            OP_ADD: begin
`ifdef ALU_FLAG_SEQ_CARRY_EN
                {carry, result_o} = {1'b0, a_i} + {1'b0, b_i};
`else
                result_o = a_i + b_i;
`endif
                ovf = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (result_o[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_SUB: begin
                result_o = a_i - b_i;
`ifdef ALU_FLAG_SEQ_CARRY_EN
                carry = (a_i >= b_i);
`endif
                ovf = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (result_o[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_AND: result_o = a_i & b_i;
            OP_OR:  result_o = a_i | b_i;
            OP_XOR: result_o = a_i ^ b_i;
            OP_NOT: result_o = ~a_i;
            OP_SHL: begin
                result_o = {a_i[WIDTH-2:0], 1'b0};
`ifdef ALU_FLAG_SEQ_CARRY_EN
                carry = a_i[WIDTH-1];
`endif
            end
            OP_SHR: begin
                result_o = {1'b0, a_i[WIDTH-1:1]};
`ifdef ALU_FLAG_SEQ_CARRY_EN
                carry = a_i[0];
`endif
            end
        endcase

        flags_o         = '0;
        flags_o[FLAG_Z] = (result_o == '0);
        flags_o[FLAG_N] = result_o[WIDTH-1];
        flags_o[FLAG_V] = ovf;
`ifdef ALU_FLAG_SEQ_CARRY_EN
        flags_o[FLAG_C] = carry;
`endif
    end

endmodule

// File: rtl/alu_flag_sequencer.sv
// Request/response ALU sequencer: IDLE -> EXEC -> FLAG -> DONE with a status register.
// Status width follows ALU_FLAG_SEQ_CARRY_EN (see package).
module alu_flag_sequencer
    import alu_flag_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [2:0]          req_op,
    input  logic [WIDTH-1:0]    req_a,
    input  logic [WIDTH-1:0]    req_b,
    input  logic                req_setflags,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [WIDTH-1:0]    res_data,
    input  logic                status_clr,
    output logic [STATUS_W-1:0] status_q
);

    state_e                state_q;
    op_e                   op_q;
    logic [WIDTH-1:0]      a_q;
    logic [WIDTH-1:0]      b_q;
    logic                  setflags_q;
    logic [WIDTH-1:0]      result_q;
    logic [WIDTH-1:0]      res_data_q;
    logic                  res_valid_q;
    logic                  req_ready_q;
    logic [STATUS_W-1:0]   status_d;

    logic [WIDTH-1:0]      alu_result;
    logic [STATUS_W-1:0]   alu_flags;

    alu_flag_compute #(
        .WIDTH(WIDTH)
    ) u_compute (
        .op_i    (op_q),
        .a_i     (a_q),
        .b_i     (b_q),
        .result_o(alu_result),
        .flags_o (alu_flags)
    );

    // Clear beats a same-cycle flag load so software can always zero the register.
    always_comb begin
        status_d = status_q;
        if (status_clr) begin
            status_d = '0;
        end else if (state_q == S_FLAG && setflags_q) begin
            status_d = alu_flags;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= OP_ADD;
            a_q         <= '0;
            b_q         <= '0;
            setflags_q  <= 1'b0;
            result_q    <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            status_q    <= '0;
        end else begin
            status_q <= status_d;
            unique case (state_q)
                S_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        op_q        <= op_e'(req_op);
                        a_q         <= req_a;
                        b_q         <= req_b;
                        setflags_q  <= req_setflags;
                        req_ready_q <= 1'b0;
                        state_q     <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    result_q <= alu_result;
                    state_q  <= S_FLAG;
                end
                S_FLAG: begin
                    // res_data only moves on entry to DONE so it holds outside DONE.
                    res_data_q  <= result_q;
                    res_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;

endmodule

// File: tb/tb_alu_flag_sequencer.sv
// Randomized self-checking bench for alu_flag_sequencer against a behavioural model.
module tb_alu_flag_sequencer;
    import alu_flag_sequencer_pkg::STATUS_W;

    localparam int unsigned W = 16;

    logic                clock;
    logic                reset;
    logic                req_valid;
    logic                req_ready;
    logic [2:0]          req_op;
    logic [W-1:0]        req_a;
    logic [W-1:0]        req_b;
    logic                req_setflags;
    logic                res_valid;
    logic                res_ready;
    logic [W-1:0]        res_data;
    logic                status_clr;
    logic [STATUS_W-1:0] status_q;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 0;

    logic         exp_ready;
    logic         exp_valid;
    logic [15:0]  exp_data;
    logic [3:0]   exp_status;

    alu_flag_sequencer #(
        .WIDTH(W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_setflags(req_setflags),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .status_clr  (status_clr),
        .status_q    (status_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: arithmetic on wide integers, status packed as {carry, ovf, neg, zero}.
    function automatic void model_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                     output logic [15:0] r, output logic [3:0] st);
        longint u;
        int     sa, sb, s;
        logic   c, v;
        sa = $signed(a);
        sb = $signed(b);
        c  = 1'b0;
        v  = 1'b0;
        r  = '0;
        case (op)
            3'd0: begin
                u = longint'(a) + longint'(b);
                r = u[15:0];
                c = (u > 65535);
                s = sa + sb;
                v = (s > 32767) || (s < -32768);
            end
            3'd1: begin
                u = longint'(a) - longint'(b);
                r = u[15:0];
                c = (a >= b);
                s = sa - sb;
                v = (s > 32767) || (s < -32768);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~a;
            3'd6: begin
                u = longint'(a) * 2;
                r = u[15:0];
                c = a[15];
            end
            default: begin
                r = a / 16'd2;
                c = a[0];
            end
        endcase
        st = {c, v, r[15], (r == 16'd0)};
    endfunction

    always @(negedge clock) begin
        if (chk_en) begin
            check("req_ready", 16'(req_ready), 16'(exp_ready));
            check("res_valid", 16'(res_valid), 16'(exp_valid));
            check("res_data", res_data, exp_data);
            check("status_q", 16'(status_q), 16'(exp_status[STATUS_W-1:0]));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            req_valid  = 1'b0;
            res_ready  = 1'($urandom_range(0, 1));
            status_clr = ($urandom_range(0, 3) == 0);
            tick();
            if (status_clr) exp_status = '0;
            status_clr = 1'b0;
        end
        res_ready = 1'b0;
    endtask

    task automatic junk();
        req_valid    = 1'($urandom_range(0, 1));
        req_op       = 3'($urandom);
        req_a        = 16'($urandom);
        req_b        = 16'($urandom);
        req_setflags = 1'($urandom);
    endtask

    task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic sf, input logic clr_flag, input int hold, input bit rst_exec,
                          input bit pin_en, input logic [15:0] pin_d, input logic [3:0] pin_s);
        logic [15:0] r;
        logic [3:0]  st;
        model_op(op, a, b, r, st);
        req_valid    = 1'b1;
        req_op       = op;
        req_a        = a;
        req_b        = b;
        req_setflags = sf;
        tick();
        exp_ready = 1'b0;
        junk();
        if (rst_exec) begin
            reset = 1'b1;
            tick();
            reset     = 1'b0;
            req_valid = 1'b0;
            exp_ready  = 1'b1;
            exp_valid  = 1'b0;
            exp_data   = '0;
            exp_status = '0;
            return;
        end
        tick();
        junk();
        status_clr = clr_flag;
        tick();
        status_clr = 1'b0;
        if (clr_flag) exp_status = '0;
        else if (sf)  exp_status = st;
        exp_valid = 1'b1;
        exp_data  = r;
        if (pin_en) begin
            check("pin_data", res_data, pin_d);
            check("pin_status", 16'(status_q), 16'(pin_s[STATUS_W-1:0]));
        end
        res_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            junk();
            tick();
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        req_valid = 1'b0;
        exp_valid = 1'b0;
        exp_ready = 1'b1;
    endtask

    initial begin
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_op       = '0;
        req_a        = '0;
        req_b        = '0;
        req_setflags = 1'b0;
        res_ready    = 1'b0;
        status_clr   = 1'b0;
        exp_ready    = 1'b1;
        exp_valid    = 1'b0;
        exp_data     = '0;
        exp_status   = '0;
        tick();
        chk_en = 1;
        tick();
        reset = 1'b0;
        idle(1);

        // Directed corner cases with literal expectations.
        run_op(3'd0, 16'h7FFF, 16'h0001, 1'b1, 1'b0, 0, 0, 1, 16'h8000, 4'b0110);
        run_op(3'd1, 16'h1234, 16'h1234, 1'b1, 1'b0, 1, 0, 1, 16'h0000, 4'b1001);
        run_op(3'd2, 16'hFF00, 16'h00FF, 1'b0, 1'b0, 0, 0, 1, 16'h0000, 4'b1001);
        run_op(3'd3, 16'h00F0, 16'h0F00, 1'b1, 1'b0, 4, 0, 1, 16'h0FF0, 4'b0000);
        run_op(3'd6, 16'hC001, 16'h0000, 1'b1, 1'b0, 0, 0, 1, 16'h8002, 4'b1010);
        run_op(3'd4, 16'hA5A5, 16'hFFFF, 1'b1, 1'b0, 0, 1, 0, 16'h0000, 4'b0000);
        idle(3);
        run_op(3'd0, 16'h8000, 16'h8000, 1'b1, 1'b1, 0, 0, 1, 16'h0000, 4'b0000);
        run_op(3'd7, 16'h8001, 16'h0000, 1'b1, 1'b0, 2, 0, 1, 16'h4000, 4'b1000);
        idle(2);

        for (int t = 0; t < 200; t++) begin
            logic [15:0] a, b;
            a = 16'($urandom);
            b = 16'($urandom);
            if ($urandom_range(0, 7) == 0) a = 16'h8000;
            if ($urandom_range(0, 7) == 0) b = a;
            if ($urandom_range(0, 7) == 0) b = 16'h7FFF;
            run_op(3'($urandom_range(0, 7)), a, b, 1'($urandom),
                   ($urandom_range(0, 7) == 0), $urandom_range(0, 3),
                   ($urandom_range(0, 19) == 0), 0, 16'h0000, 4'b0000);
            idle($urandom_range(0, 2));
        end

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_flag_sequencer.md
ALU_FLAG_SEQUENCER -- requirements
Module: alu_flag_sequencer

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the data path width in bits (minimum 2).
REQ-002 clock, input, 1: SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset, input, 1: SHALL be a synchronous, active-high reset.
REQ-004 req_valid, input, 1: SHALL flag that an operation request is present.
REQ-005 req_ready, output, 1: SHALL flag that the block can accept a request.
REQ-006 req_op, input, 3: SHALL select the operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT a, 6 SHL a by 1, 7 SHR a by 1 (logical).
REQ-007 req_a and req_b, input, WIDTH each: SHALL carry the operands.
REQ-008 req_setflags, input, 1: SHALL request a status register update for this operation.
REQ-009 res_valid, output, 1: SHALL flag that the result is valid.
REQ-010 res_ready, input, 1: SHALL flag that the consumer takes the result.
REQ-011 res_data, output, WIDTH: SHALL carry the operation result.
REQ-012 status_clr, input, 1: SHALL request a synchronous clear of the status register.
REQ-013 status_q, output, STATUS_W: SHALL present the status register: bit 2 overflow, bit 1 negative, bit 0 zero.

Function
REQ-014 The FSM SHALL have four states, IDLE, EXEC, FLAG and DONE, with req_ready high only in IDLE.
REQ-015 From IDLE, req_valid && req_ready SHALL capture req_op, req_a, req_b and req_setflags and move to EXEC; otherwise the FSM stays in IDLE.
REQ-016 EXEC SHALL compute the result into a WIDTH-bit register, truncated modulo 2^WIDTH, then move to FLAG.
REQ-017 FLAG SHALL load status_q when the captured setflags is 1 (otherwise hold it), then move to DONE.
REQ-018 Flags: zero = (result == 0) across all WIDTH bits; negative = result[WIDTH-1]; overflow = signed two's-complement overflow for ADD and SUB, 0 for ops 2-7.
REQ-019 DONE SHALL assert res_valid with res_data stable, and hold both until res_ready is 1.
REQ-020 On res_valid && res_ready the FSM SHALL return to IDLE; accept-to-res_valid latency is exactly 3 cycles.
REQ-021 status_clr SHALL zero status_q on the next edge in any state, and SHALL win over a simultaneous FLAG update.
REQ-022 req_valid outside IDLE SHALL be ignored (no capture, no side effect).
REQ-023 res_data SHALL hold its last value outside DONE.

Reset
REQ-024 Reset SHALL force IDLE, req_ready=1, res_valid=0, res_data=0, status_q=0 on the next edge, including mid-operation, and SHALL discard any in-flight operation.
REQ-025 Reset SHALL take priority over status_clr and all handshakes.

Configuration
REQ-026 With macro ALU_FLAG_SEQ_CARRY_EN defined, STATUS_W SHALL be 4, and status_q[3] SHALL be the carry flag.
REQ-027 Carry flag meaning: ADD carry-out; SUB no-borrow (a >= b unsigned); SHL the shifted-out MSB; SHR the shifted-out LSB; 0 for ops 2-5.
REQ-028 Without the macro, STATUS_W SHALL be 3, and no carry logic SHALL be present.

Structure
REQ-029 A shared package SHALL hold the op encoding enum, the FSM state enum, and the STATUS_W constant selected by the macro.
REQ-030 The datapath (result and flag compute) SHALL be one combinational sub-module, alu_flag_compute; the FSM and registers stay in alu_flag_sequencer.

Verification (WIDTH=16)
REQ-031 ADD 0x7FFF + 0x0001 with setflags=1 -> res_data 0x8000, status_q 3'b110, res_valid 3 cycles after accept.
REQ-032 SUB 0x1234 - 0x1234 with setflags=1 -> res_data 0x0000, status_q 3'b001; with the macro, status_q[3]=1.
REQ-033 status_q=3'b001, then AND 0xFF00 & 0x00FF with setflags=0 -> res_data 0x0000, status_q unchanged at 3'b001.
REQ-034 res_ready held low 4 cycles in DONE -> res_valid and res_data held, req_ready=0, new req_valid ignored; res_ready=1 -> IDLE next cycle.
REQ-035 Reset asserted during EXEC -> next cycle IDLE, res_valid=0, status_q=0, and no result is ever presented.
REQ-036 status_clr=1 in the FLAG cycle of ADD 0x8000 + 0x8000 with setflags=1 -> status_q=0, res_data 0x0000 still delivered.
